// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the Game Boy interrupt controller: source bit
// indices, register addresses, FSM state encoding and the vector helper.
package interrupt_controller_pkg;

  localparam int IDX_W = 3;

  // Source bit positions in IF/IE (bit 0 = highest priority)
  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  // Register addresses; decode happens upstream and arrives as hit strobes
  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  typedef enum logic {
    INT_IDLE    = 1'b0,
    INT_PRESENT = 1'b1
  } int_state_e;

  // Vector for source idx: base + idx * stride
  function automatic logic [15:0] irq_vector(input logic [15:0]      base,
                                             input logic [15:0]      stride,
                                             input logic [IDX_W-1:0] idx);
    return base + 16'(idx) * stride;
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Bus strobes, request pulses and CPU interrupt handshake of the interrupt
// controller. The 8-bit data bus stays a plain inout on the top module.
interface interrupt_controller_if #(
  parameter int NUM_SRC = 5
);
  logic               addr_in_IF;
  logic               addr_in_IE;
  logic               mem_we;
  logic               mem_re;
  logic [NUM_SRC-1:0] irq_src;
  logic               cpu_int_ack;
  logic               cpu_int_req;
  logic [15:0]        cpu_int_vector;
  logic               cpu_wake;

  // CPU / peripheral side
  modport master (
    output addr_in_IF, addr_in_IE, mem_we, mem_re, irq_src, cpu_int_ack,
    input  cpu_int_req, cpu_int_vector, cpu_wake
  );

  // Interrupt controller side
  modport slave (
    input  addr_in_IF, addr_in_IE, mem_we, mem_re, irq_src, cpu_int_ack,
    output cpu_int_req, cpu_int_vector, cpu_wake
  );
endinterface

// File: rtl/interrupt_controller_priority_enc.sv
// Fixed-priority encoder: lowest-index set bit of pend wins.
module int_priority_enc
  import interrupt_controller_pkg::*;
#(
  parameter int NUM_SRC = 5
) (
  input  logic [NUM_SRC-1:0] pend,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);
  // Scan high to low so the lowest set index is the last one written
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/tristate.sv
// Generic tristate bus driver: drives din onto io while oe, else releases.
module tristate #(
  parameter int W = 8
) (
  input  logic         oe,
  input  logic [W-1:0] din,
  inout  wire  [W-1:0] io
);
  assign io = oe ? din : {W{1'bz}};
endmodule

// File: rtl/interrupt_controller.sv
// Game Boy interrupt controller. Holds IF (FF0F) and IE (FFFF), latches
// single-cycle request pulses and presents the highest-priority enabled
// pending source to the CPU, clearing its IF bit on acknowledge.
// Optional debug tap: define INT_CHIPSCOPE_EN to add int_chipscope[19:0].
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int          NUM_SRC       = 5,
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter logic [15:0] VECTOR_STRIDE = 16'h0008
) (
  input  logic                 cpu_clock,
  input  logic                 reset,
  inout  wire  [7:0]           data_ext,
`ifdef INT_CHIPSCOPE_EN
  output logic [19:0]          int_chipscope,
`endif
  interrupt_controller_if.slave bus
);

  logic [NUM_SRC-1:0] if_reg;
  logic [NUM_SRC-1:0] if_next;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] ack_clear;
  logic [7:0]         ie_reg;
  logic               wr_if;
  logic               wr_ie;
  logic               rd_if;
  logic               rd_ie;
  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   idx_reg;
  logic               ack_take;
  logic               req_reg;
  logic [15:0]        vector_reg;
  int_state_e         state;

  assign wr_if = bus.mem_we & bus.addr_in_IF;
  assign wr_ie = bus.mem_we & bus.addr_in_IE;
  assign rd_if = bus.mem_re & bus.addr_in_IF;
  assign rd_ie = bus.mem_re & bus.addr_in_IE;

  // Only the low IE bits gate requests; upper IE bits are plain storage
  assign pend = if_reg & ie_reg[NUM_SRC-1:0];

  int_priority_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .pend  (pend),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // An ack only counts while the presented source is still pending; once
  // it has been withdrawn by a CPU write the ack has nothing to take.
  assign ack_take = (state == INT_PRESENT) & bus.cpu_int_ack & pend[idx_reg];

  // Acknowledge clears just the bit that was presented
  always_comb begin
    ack_clear = '0;
    if (ack_take) ack_clear[idx_reg] = 1'b1;
  end

  // A source pulse wins over a same-cycle write of 0 or ack clear
  assign if_next = ((wr_if ? data_ext[NUM_SRC-1:0] : if_reg) & ~ack_clear)
                 | bus.irq_src;

  // IF / IE register state
  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      if_reg <= '0;
      ie_reg <= '0;
    end else begin
      if_reg <= if_next;
      if (wr_ie) ie_reg <= data_ext;
    end
  end

  // Presentation FSM: latch the winner, hold its vector until ack/withdraw
  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      state      <= INT_IDLE;
      idx_reg    <= '0;
      req_reg    <= 1'b0;
      vector_reg <= '0;
    end else begin
      case (state)
        INT_IDLE: begin
          if (win_valid) begin
            state      <= INT_PRESENT;
            idx_reg    <= win_idx;
            req_reg    <= 1'b1;
            vector_reg <= irq_vector(VECTOR_BASE, VECTOR_STRIDE, win_idx);
          end
        end
        INT_PRESENT: begin
          // Higher-priority arrivals do not preempt; leave on ack or withdraw
          if (!pend[idx_reg] || bus.cpu_int_ack) begin
            state   <= INT_IDLE;
            req_reg <= 1'b0;
          end
        end
        default: begin
          state   <= INT_IDLE;
          req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_int_req    = req_reg;
  assign bus.cpu_int_vector = vector_reg;
  assign bus.cpu_wake       = |pend;

  // Register readback onto the shared CPU data bus; unused IF bits read 1
  tristate #(.W(8)) u_if_rd (
    .oe  (rd_if),
    .din ({{(8 - NUM_SRC){1'b1}}, if_reg}),
    .io  (data_ext)
  );

  tristate #(.W(8)) u_ie_rd (
    .oe  (rd_ie),
    .din (ie_reg),
    .io  (data_ext)
  );

`ifdef INT_CHIPSCOPE_EN
  assign int_chipscope = {if_reg, ie_reg[NUM_SRC-1:0], bus.irq_src,
                          bus.cpu_int_ack, req_reg, state, bus.cpu_wake, 1'b0};
`endif

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with a spec-level reference model.
module tb_interrupt_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wire  [7:0] data_ext;
  logic       tb_oe   = 1'b0;
  logic [7:0] tb_data = 8'h00;
  assign data_ext = tb_oe ? tb_data : 8'hzz;

  // Weak pull so a released bus reads back as all ones
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data_ext[g]);
  end

  interrupt_controller_if #(.NUM_SRC(5)) bus ();

`ifdef INT_CHIPSCOPE_EN
  logic [19:0] cs;
`endif

  interrupt_controller dut (
    .cpu_clock     (clk),
    .reset         (rst),
    .data_ext      (data_ext),
`ifdef INT_CHIPSCOPE_EN
    .int_chipscope (cs),
`endif
    .bus           (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  logic [4:0] m_if;
  logic [7:0] m_ie;
  logic       m_present;
  logic [2:0] m_idx;
  logic [4:0] m_pend;
  logic [4:0] m_clr;

  function automatic int lowest(input logic [4:0] p);
    int r = -1;
    for (int i = 4; i >= 0; i--) if (p[i]) r = i;
    return r;
  endfunction

  always_comb begin
    m_pend = m_if & m_ie[4:0];
    m_clr  = 5'd0;
    if (m_present && m_pend[m_idx] && bus.cpu_int_ack) m_clr[m_idx] = 1'b1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_if      <= 5'd0;
      m_ie      <= 8'd0;
      m_present <= 1'b0;
      m_idx     <= 3'd0;
    end else begin
      m_if <= (((bus.mem_we && bus.addr_in_IF) ? data_ext[4:0] : m_if) & ~m_clr) | bus.irq_src;
      if (bus.mem_we && bus.addr_in_IE) m_ie <= data_ext;
      if (m_present) begin
        if (!m_pend[m_idx] || bus.cpu_int_ack) m_present <= 1'b0;
      end else if (m_pend != 5'd0) begin
        m_present <= 1'b1;
        m_idx     <= 3'(lowest(m_pend));
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("req_vs_model", 32'(bus.cpu_int_req), 32'(m_present));
      chk("wake_vs_model", 32'(bus.cpu_wake), 32'(|(m_if & m_ie[4:0])));
      if (m_present)
        chk("vector_vs_model", 32'(bus.cpu_int_vector), 32'h40 + 32'(m_idx) * 32'd8);
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic wr(input logic sel_ie, input logic [7:0] v);
    bus.addr_in_IF = !sel_ie;
    bus.addr_in_IE = sel_ie;
    bus.mem_we     = 1'b1;
    tb_oe          = 1'b1;
    tb_data        = v;
    @(negedge clk);
    bus.addr_in_IF = 1'b0;
    bus.addr_in_IE = 1'b0;
    bus.mem_we     = 1'b0;
    tb_oe          = 1'b0;
  endtask

  task automatic rd(input logic sel_ie, input logic [7:0] exp, input string name);
    bus.addr_in_IF = !sel_ie;
    bus.addr_in_IE = sel_ie;
    bus.mem_re     = 1'b1;
    #1;
    chk(name, 32'(data_ext), 32'(exp));
    chk({name, "_model"}, 32'(data_ext), sel_ie ? 32'(m_ie) : 32'({3'b111, m_if}));
    @(negedge clk);
    bus.addr_in_IF = 1'b0;
    bus.addr_in_IE = 1'b0;
    bus.mem_re     = 1'b0;
  endtask

  task automatic pulse(input logic [4:0] v);
    bus.irq_src = v;
    @(negedge clk);
    bus.irq_src = 5'd0;
  endtask

  task automatic ack();
    bus.cpu_int_ack = 1'b1;
    @(negedge clk);
    bus.cpu_int_ack = 1'b0;
  endtask

  task automatic wait_req(input string name, input int max_cyc);
    int n = 0;
    while (!bus.cpu_int_req && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(bus.cpu_int_req), 32'd1);
  endtask

  task automatic expect_req(input string name, input logic r, input logic [15:0] vec);
    chk({name, "_req"}, 32'(bus.cpu_int_req), 32'(r));
    if (r) chk({name, "_vec"}, 32'(bus.cpu_int_vector), 32'(vec));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.addr_in_IF  = 1'b0;
    bus.addr_in_IE  = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_re      = 1'b0;
    bus.irq_src     = 5'd0;
    bus.cpu_int_ack = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", 32'(bus.cpu_int_req), 32'd0);
    chk("rst_vector", 32'(bus.cpu_int_vector), 32'h0000);
    chk("rst_wake", 32'(bus.cpu_wake), 32'd0);
    chk("rst_bus_released", 32'(data_ext), 32'hFF);
    @(negedge clk);
    rst = 1'b0;

    // 1: reset readback, bus release, upper IE bits do not gate
    rd(1'b0, 8'hE0, "if_reset");
    rd(1'b1, 8'h00, "ie_reset");
    #1 chk("bus_released", 32'(data_ext), 32'hFF);
    @(negedge clk);
    wr(1'b1, 8'hE0);
    rd(1'b1, 8'hE0, "ie_upper_bits");
    pulse(5'h1F);
    @(negedge clk);
    chk("upper_ie_no_req", 32'(bus.cpu_int_req), 32'd0);
    chk("upper_ie_no_wake", 32'(bus.cpu_wake), 32'd0);
    rd(1'b0, 8'hFF, "if_all_set");
    wr(1'b0, 8'h00);
    rd(1'b0, 8'hE0, "if_written_zero");

    // 2: single serial source, two-cycle latency, ack clears
    wr(1'b1, 8'h08);
    pulse(5'h08);
    expect_req("lat_edge1", 1'b0, 16'h0000);
    @(negedge clk);
    expect_req("lat_edge2", 1'b1, 16'h0058);
    ack();
    expect_req("after_ack", 1'b0, 16'h0000);
    rd(1'b0, 8'hE0, "if_after_ack");

    // 3: simultaneous joypad + vblank, priority then back-to-back
    wr(1'b1, 8'h1F);
    pulse(5'h11);
    @(negedge clk);
    expect_req("prio_first", 1'b1, 16'h0040);
    ack();
    expect_req("b2b_gap", 1'b0, 16'h0000);
    @(negedge clk);
    expect_req("prio_second", 1'b1, 16'h0060);
    ack();
    rd(1'b0, 8'hE0, "if_after_both");

    // 4: vector held while a higher-priority source arrives
    pulse(5'h04);
    @(negedge clk);
    expect_req("timer_present", 1'b1, 16'h0050);
    pulse(5'h01);
    expect_req("timer_hold1", 1'b1, 16'h0050);
    @(negedge clk);
    expect_req("timer_hold2", 1'b1, 16'h0050);
    ack();
    expect_req("timer_acked", 1'b0, 16'h0000);
    @(negedge clk);
    expect_req("vblank_next", 1'b1, 16'h0040);
    ack();
    rd(1'b0, 8'hE0, "if_after_hold");

    // 5: write IF=0 and stat pulse in the same cycle; pulse wins
    bus.mem_we     = 1'b1;
    bus.addr_in_IF = 1'b1;
    tb_oe          = 1'b1;
    tb_data        = 8'h00;
    bus.irq_src    = 5'h02;
    @(negedge clk);
    bus.mem_we     = 1'b0;
    bus.addr_in_IF = 1'b0;
    tb_oe          = 1'b0;
    bus.irq_src    = 5'd0;
    rd(1'b0, 8'hE2, "pulse_beats_write");
    wait_req("stat_req", 4);
    expect_req("stat_present", 1'b1, 16'h0048);
    ack();
    rd(1'b0, 8'hE0, "if_after_stat");

    // 6: withdraw by clearing IE, ack while idle, reset during PRESENT
    pulse(5'h08);
    @(negedge clk);
    expect_req("serial_present", 1'b1, 16'h0058);
    wr(1'b1, 8'h00);
    @(negedge clk);
    expect_req("withdrawn", 1'b0, 16'h0000);
    chk("withdrawn_wake", 32'(bus.cpu_wake), 32'd0);
    rd(1'b0, 8'hE8, "if_kept_after_withdraw");
    rd(1'b1, 8'h00, "ie_cleared");
    ack();
    rd(1'b0, 8'hE8, "ack_idle_ignored");
    wr(1'b1, 8'h08);
    wait_req("pre_reset_req", 4);
    #2 rst = 1'b1;
    #1;
    chk("midrst_req", 32'(bus.cpu_int_req), 32'd0);
    chk("midrst_vector", 32'(bus.cpu_int_vector), 32'h0000);
    chk("midrst_wake", 32'(bus.cpu_wake), 32'd0);
    chk("midrst_bus", 32'(data_ext), 32'hFF);
    @(negedge clk);
    rst = 1'b0;
    rd(1'b0, 8'hE0, "if_after_midrst");
    rd(1'b1, 8'h00, "ie_after_midrst");
    @(negedge clk);
    expect_req("idle_after_midrst", 1'b0, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
